// File: rtl/decode_pkg.sv
// Decode-stage types shared by decode, the decoded-instruction queue and issue.
package decode_pkg;

  localparam int DIQ_DEPTH     = 8;
  localparam int DIQ_IN_WIDTH  = 2;
  localparam int DIQ_OUT_WIDTH = 2;

  typedef logic [$clog2(DIQ_DEPTH)-1:0] diq_ptr_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic        in_delay_slot;
  } decode_data_t;

endpackage

// File: rtl/decoded_instr_queue_popcount.sv
// Counts the contiguous run of set lanes starting at lane 0; contig drops on any gap.
module diq_popcount #(
  parameter int W = 2
) (
  input  logic [W-1:0]             vld,
  output logic [$clog2(W+1)-1:0]   cnt,
  output logic                     contig
);

  logic gap;

  always_comb begin
    cnt    = '0;
    contig = 1'b1;
    gap    = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (vld[i]) begin
        if (gap) contig = 1'b0;
        else     cnt = ($clog2(W+1))'(i + 1);
      end else begin
        gap = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decoded_instr_queue.sv
// Multi-lane decode->issue FIFO: 1-cycle latency (0 when empty with DIQ_BYPASS_EN),
// in_ready needs IN_WIDTH free slots from current count only; flush empties the queue.
module decoded_instr_queue
  import decode_pkg::*;
#(
  parameter int DEPTH     = DIQ_DEPTH,
  parameter int IN_WIDTH  = DIQ_IN_WIDTH,
  parameter int OUT_WIDTH = DIQ_OUT_WIDTH
) (
  input  logic                               clk,
  input  logic                               resetn,
  input  logic                               flush,
  input  logic [IN_WIDTH-1:0]                in_valid,
  input  decode_data_t [IN_WIDTH-1:0]        in_data,
  output logic                               in_ready,
  output logic [OUT_WIDTH-1:0]               out_valid,
  output decode_data_t [OUT_WIDTH-1:0]       out_data,
  input  logic [$clog2(OUT_WIDTH+1)-1:0]     out_pop,
  output logic [$clog2(DEPTH+1)-1:0]         count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(IN_WIDTH+1);
  localparam int OW = $clog2(OUT_WIDTH+1);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  decode_data_t  mem [DEPTH];

  logic [IW-1:0] in_cnt;
  logic          in_contig;
  logic [IW-1:0] push_cnt;
  logic [OW-1:0] avail_cnt;
  logic          avail_contig;

  diq_popcount #(.W(IN_WIDTH)) u_in_cnt (
    .vld    (in_valid),
    .cnt    (in_cnt),
    .contig (in_contig)
  );

  diq_popcount #(.W(OUT_WIDTH)) u_out_cnt (
    .vld    (out_valid),
    .cnt    (avail_cnt),
    .contig (avail_contig)
  );

  // No pop credit: readiness depends only on what is already stored.
  assign in_ready = (count <= CW'(DEPTH - IN_WIDTH));
  assign push_cnt = in_ready ? in_cnt : '0;

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      out_valid[i] = (count > CW'(i));
      out_data[i]  = mem[head + PW'(i)];
    end
`ifdef DIQ_BYPASS_EN
    if (count == '0 && !flush) begin
      out_valid = '0;
      out_data  = '0;
      for (int i = 0; i < ((IN_WIDTH < OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH); i++) begin
        out_valid[i] = in_valid[i];
        out_data[i]  = in_data[i];
      end
    end
`endif
  end

  // Bypassed lanes are written too; advancing head by the pop count retires them at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= tail;
      count <= '0;
    end else begin
      for (int i = 0; i < IN_WIDTH; i++) begin
        if (IW'(i) < push_cnt) mem[tail + PW'(i)] <= in_data[i];
      end
      tail  <= tail + PW'(push_cnt);
      head  <= head + PW'(out_pop);
      count <= count + CW'(push_cnt) - CW'(out_pop);
    end
  end

  always @(posedge clk) begin
    if (resetn && !flush) begin
      assert (!in_ready || in_contig);
      assert (avail_contig);
      assert (out_pop <= avail_cnt);
    end
  end

endmodule

// File: tb/tb_decoded_instr_queue.sv
// Directed + random bench for decoded_instr_queue against a queue-based reference model.
module tb_decoded_instr_queue;
  import decode_pkg::*;

  localparam int DEPTH = 8;
  localparam int IN_W  = 2;
  localparam int OUT_W = 2;
  localparam int OPW   = $clog2(OUT_W+1);
  localparam int CW    = $clog2(DEPTH+1);

  logic                      clk;
  logic                      resetn;
  logic                      flush;
  logic [IN_W-1:0]           in_valid;
  decode_data_t [IN_W-1:0]   in_data;
  logic                      in_ready;
  logic [OUT_W-1:0]          out_valid;
  decode_data_t [OUT_W-1:0]  out_data;
  logic [OPW-1:0]            out_pop;
  logic [CW-1:0]             count;

  decode_data_t model_q[$];
  int n_chk  = 0;
  int n_fail = 0;
  int next_tag = 0;

  decoded_instr_queue #(.DEPTH(DEPTH), .IN_WIDTH(IN_W), .OUT_WIDTH(OUT_W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_pop   (out_pop),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check outputs against the model, then retire/accept in the model.
  task automatic step(input int npush, input int npop, input bit fl);
    int sz;
    bit rdy;
    bit byp;
    int ev;
    bit exp_v;
    decode_data_t d;
    sz  = model_q.size();
    rdy = (sz <= DEPTH - IN_W);
    byp = 1'b0;
`ifdef DIQ_BYPASS_EN
    byp = (sz == 0) && !fl;
`endif
    if (byp) ev = (npush < OUT_W) ? npush : OUT_W;
    else     ev = (sz < OUT_W) ? sz : OUT_W;
    if (npop > ev) npop = ev;
    in_valid = '0;
    for (int i = 0; i < IN_W; i++) begin
      d.pc            = next_tag;
      d.instr         = $urandom;
      d.rd            = 5'($urandom);
      d.in_delay_slot = 1'($urandom);
      next_tag++;
      in_data[i] = d;
      if (i < npush) in_valid[i] = 1'b1;
    end
    out_pop = OPW'(npop);
    flush   = fl;
    #1;
    chk("count", 128'(count), 128'(sz));
    chk("in_ready", 128'(in_ready), 128'(rdy));
    for (int i = 0; i < OUT_W; i++) begin
      exp_v = byp ? (i < npush) : (i < sz);
      chk("out_valid", 128'(out_valid[i]), 128'(exp_v));
      if (exp_v) chk("out_data", 128'(out_data[i]), byp ? 128'(in_data[i]) : 128'(model_q[i]));
    end
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (rdy) for (int i = 0; i < npush; i++) model_q.push_back(in_data[i]);
      for (int i = 0; i < npop; i++) void'(model_q.pop_front());
    end
    @(negedge clk);
    flush    = 1'b0;
    in_valid = '0;
    out_pop  = '0;
  endtask

  initial begin
    resetn   = 1'b0;
    flush    = 1'b0;
    in_valid = '0;
    in_data  = '0;
    out_pop  = '0;
    #1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Fill until in_ready drops at 7, try a blocked push, then pop 2.
    repeat (3) step(2, 0, 0);
    step(1, 0, 0);
    step(2, 0, 0);
    step(0, 2, 0);

    // Asynchronous reset mid-cycle with 5 entries stored.
    chk("pre_rst_count", 128'(count), 128'(5));
    in_data = '0;
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_count", 128'(count), 128'(0));
    chk("async_rst_out_valid", 128'(out_valid), 128'(0));
    chk("async_rst_in_ready", 128'(in_ready), 128'(1));
    model_q.delete();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Steady push 2 / pop 2 at count 4 wraps the pointers several times.
    repeat (2) step(2, 0, 0);
    repeat (8) step(2, 2, 0);
    repeat (2) step(0, 2, 0);

    // Single-lane pushes.
    repeat (3) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 2, 0);
    step(0, 1, 0);

    // Flush with concurrent push and pop, then fresh traffic.
    repeat (3) step(2, 0, 0);
    step(2, 1, 1);
    step(0, 0, 0);
    step(2, 0, 0);
    step(0, 2, 0);

    // From empty: push 2, pop 1 (pop is clamped to 0 without bypass).
    step(2, 1, 0);
    step(0, 0, 0);
    step(0, 2, 0);

    repeat (400) begin
      step($urandom_range(0, IN_W), $urandom_range(0, OUT_W), ($urandom_range(0, 19) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
